// File: rtl/lif_pkg.sv
// Shared constants, FSM state type and the leak/integrate arithmetic for the
// time-multiplexed LIF neuron scheduler.
package lif_pkg;

  localparam int unsigned DEF_STATE_W    = 8;
  localparam int unsigned DEF_CUR_W      = 12;
  localparam int unsigned DEF_THRESHOLD  = 200;
  localparam int unsigned DEF_LEAK_SHIFT = 1;
  localparam int unsigned DEF_REFRAC     = 2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } lif_state_t;

  // state - (state >> leak_shift) + cur, saturated to 2^state_w - 1.
  // Operands arrive zero-extended to 32 bits; the 33-bit sum cannot wrap, so
  // the result equals the narrower max(STATE_W, CUR_W)+1 formulation.
  function automatic logic [31:0] leak_integrate(input logic [31:0] state,
                                                 input logic [31:0] cur,
                                                 input int unsigned leak_shift,
                                                 input int unsigned state_w);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, state - (state >> leak_shift)} + {1'b0, cur};
    max_v = (33'd1 << state_w) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_scheduler_if.sv
// Spike event handshake between the scheduler's output FIFO and its consumer.
interface lif_scheduler_if #(
  parameter int unsigned NW = 2
);
  logic          spike_valid;
  logic [NW-1:0] spike_id;
  logic          spike_ready;

  modport master (output spike_valid, output spike_id, input spike_ready);
  modport slave  (input spike_valid, input spike_id, output spike_ready);
endinterface

// File: rtl/lif_scheduler_spike_fifo.sv
// Synchronous FIFO for spike events: valid/ready pop, drop-on-full push.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// DEPTH is expected to be a power of two, at least 2.
module spike_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          accept;

  // Handshake decode: a pop frees the slot a same-cycle push needs.
  always_comb begin
    valid  = (count != '0);
    full   = (count == FULL_CNT);
    pop    = valid & pop_ready;
    accept = push & (~full | pop);
    drop   = push & full & ~pop;
    head   = mem[rd_ptr];
  end

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Leaky integrate-and-fire scheduler: one shared datapath scans all neurons,
// one per cycle, on each tick; firing neurons enqueue their index as events.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS  = 4,
  parameter int unsigned STATE_W    = DEF_STATE_W,
  parameter int unsigned CUR_W      = DEF_CUR_W,
  parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned REFRAC     = DEF_REFRAC,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  output logic [NW-1:0]      cur_idx,
  input  logic [CUR_W-1:0]   cur_data,
  output logic               busy,
  output logic               tick_done,
  lif_scheduler_if.master    spk,
  output logic               overflow,
  output logic               tick_missed,
  input  logic               clr_flags,
  input  logic [NW-1:0]      obs_sel,
  output logic [STATE_W-1:0] obs_state
);

  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [NW-1:0] LAST = NW'(N_NEURONS - 1);

  lif_state_t        fsm;
  logic [STATE_W-1:0] state_q  [N_NEURONS];
  logic [RW-1:0]      refrac_q [N_NEURONS];
  logic [31:0]        next_sum;
  logic               in_refrac;
  logic               fire;
  logic               fifo_drop;
  logic               fifo_valid;
  logic [NW-1:0]      fifo_head;

  // Datapath for the neuron selected by cur_idx this cycle.
  always_comb begin
    next_sum  = leak_integrate(32'(state_q[cur_idx]), 32'(cur_data), LEAK_SHIFT, STATE_W);
    in_refrac = (refrac_q[cur_idx] != '0);
    fire      = (fsm == SCAN) && !in_refrac && (next_sum >= 32'(THRESHOLD));
  end

  // Scan sequencer with registered busy/tick_done/cur_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      cur_idx   <= '0;
      busy      <= 1'b0;
      tick_done <= 1'b0;
    end else begin
      tick_done <= 1'b0;
      unique case (fsm)
        IDLE: if (tick) begin
          fsm     <= SCAN;
          cur_idx <= '0;
          busy    <= 1'b1;
        end
        SCAN: if (cur_idx == LAST) begin
          fsm       <= DONE;
          tick_done <= 1'b1;
        end else begin
          cur_idx <= cur_idx + 1'b1;
        end
        DONE: begin
          fsm  <= IDLE;
          busy <= 1'b0;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Membrane/refractory update for the scanned neuron, plus observation tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        state_q[i]  <= '0;
        refrac_q[i] <= '0;
      end
      obs_state <= '0;
    end else begin
      obs_state <= state_q[obs_sel];
      if (fsm == SCAN) begin
        if (in_refrac) begin
          state_q[cur_idx]  <= '0;
          refrac_q[cur_idx] <= refrac_q[cur_idx] - 1'b1;
        end else if (fire) begin
          state_q[cur_idx]  <= '0;
          refrac_q[cur_idx] <= RW'(REFRAC);
        end else begin
          state_q[cur_idx] <= next_sum[STATE_W-1:0];
        end
      end
    end
  end

  // Sticky error flags; a new set event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      tick_missed <= 1'b0;
    end else begin
      overflow    <= fifo_drop | (overflow & ~clr_flags);
      tick_missed <= (tick && (fsm != IDLE)) | (tick_missed & ~clr_flags);
    end
  end

  spike_fifo #(
    .W     (NW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (cur_idx),
    .pop_ready (spk.spike_ready),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .drop      (fifo_drop)
  );

  assign spk.spike_valid = fifo_valid;
  assign spk.spike_id    = fifo_head;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: expected spike ids are queued as stimulus
// is issued and a monitor compares them against each accepted FIFO pop.
module tb_lif_scheduler;

  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          clr_flags = 1'b0;
  logic [NW-1:0] obs_sel = '0;
  logic [NW-1:0] cur_idx;
  logic [11:0]   cur_data;
  logic          busy;
  logic          tick_done;
  logic          overflow;
  logic          tick_missed;
  logic [7:0]    obs_state;
  logic [11:0]   cur_tab [4];

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  lif_scheduler_if #(.NW(NW)) spk ();

  lif_scheduler #(
    .N_NEURONS  (4),
    .STATE_W    (8),
    .CUR_W      (12),
    .THRESHOLD  (200),
    .LEAK_SHIFT (1),
    .REFRAC     (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .cur_idx     (cur_idx),
    .cur_data    (cur_data),
    .busy        (busy),
    .tick_done   (tick_done),
    .spk         (spk),
    .overflow    (overflow),
    .tick_missed (tick_missed),
    .clr_flags   (clr_flags),
    .obs_sel     (obs_sel),
    .obs_state   (obs_state)
  );

  always #5 clk = ~clk;

  // External current mux, combinational on cur_idx.
  assign cur_data = cur_tab[cur_idx];

  // Monitor: every accepted pop is compared with the oldest expected id.
  always @(negedge clk) begin
    int e;
    if (rst_n && spk.spike_valid && spk.spike_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spike_unexpected act=%0d exp=none", spk.spike_id);
      end else begin
        e = exp_q.pop_front();
        if (int'(spk.spike_id) != e) begin
          failures++;
          $display("FAIL spike_id act=%0d exp=%0d", spk.spike_id, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp_v);
    end
  endtask

  task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
    cur_tab[0] = 12'(c0);
    cur_tab[1] = 12'(c1);
    cur_tab[2] = 12'(c2);
    cur_tab[3] = 12'(c3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, tick_done, 0);
    chk({tag, "_valid"}, spk.spike_valid, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_missed"}, tick_missed, 0);
    chk({tag, "_obs"}, obs_state, 0);
    chk({tag, "_idx"}, cur_idx, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick = 1'b0;
    clr_flags = 1'b0;
    spk.spike_ready = 1'b0;
    obs_sel = '0;
    step();
    check_reset_outputs("rst");
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic finish_scan();
    int n = 0;
    while (tick_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("done_seen", tick_done, 1);
    step();
    chk("idle_after", busy, 0);
  endtask

  task automatic scan();
    pulse_tick();
    finish_scan();
  endtask

  task automatic obs(input int i, input int exp_v, input string nm);
    obs_sel = NW'(i);
    step();
    chk(nm, obs_state, exp_v);
  endtask

  task automatic drain();
    int n = 0;
    spk.spike_ready = 1'b1;
    while (exp_q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    spk.spike_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", spk.spike_valid, 0);
  endtask

  initial begin
    int cnt;
    spk.spike_ready = 1'b0;
    set_cur(0, 0, 0, 0);

    // 1: idle scan timing, no activity with zero currents
    do_reset();
    pulse_tick();
    for (int k = 1; k <= 6; k++) begin
      chk("t1_busy", busy, (k <= 5));
      chk("t1_done", tick_done, (k == 5));
      if (k <= 4) chk("t1_idx", cur_idx, k - 1);
      step();
    end
    for (int i = 0; i < 4; i++) obs(i, 0, "t1_state");
    chk("t1_valid", spk.spike_valid, 0);

    // 2: single neuron integrate / fire / refractory cycle
    do_reset();
    set_cur(150, 0, 0, 0);
    scan();
    obs(0, 150, "t2_tick1");
    obs_sel = 2'd1;
    #1;
    chk("t2_obs_hold", obs_state, 150);
    step();
    chk("t2_obs_new", obs_state, 0);
    exp_q.push_back(0);
    scan();
    chk("t2_valid", spk.spike_valid, 1);
    obs(0, 0, "t2_tick2");
    scan();
    obs(0, 0, "t2_tick3");
    scan();
    obs(0, 0, "t2_tick4");
    scan();
    obs(0, 150, "t2_tick5");
    exp_q.push_back(0);
    scan();
    obs(0, 0, "t2_tick6");
    drain();

    // 3: saturation on a large current
    do_reset();
    set_cur(0, 0, 4095, 0);
    exp_q.push_back(2);
    scan();
    chk("t3_head", spk.spike_id, 2);
    obs(2, 0, "t3_state2");
    drain();

    // 4: full FIFO, drops, ordered drain, flag clear
    do_reset();
    set_cur(4095, 4095, 4095, 4095);
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    scan();
    chk("t4_valid", spk.spike_valid, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t4_id_stable", spk.spike_id, 0);
      step();
    end
    scan();
    scan();
    chk("t4_ovf_refrac", overflow, 0);
    scan();
    chk("t4_ovf_set", overflow, 1);
    drain();
    chk("t4_ovf_sticky", overflow, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t4_ovf_clr", overflow, 0);

    // 5: missed tick, then push and pop together on a full FIFO
    do_reset();
    set_cur(4095, 4095, 4095, 4095);
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    pulse_tick();
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (tick_done === 1'b1) cnt++;
      step();
    end
    chk("t5_done_count", cnt, 1);
    chk("t5_missed", tick_missed, 1);
    set_cur(4095, 0, 0, 0);
    scan();
    scan();
    pulse_tick();
    spk.spike_ready = 1'b1;
    exp_q.push_back(0);
    step();
    spk.spike_ready = 1'b0;
    finish_scan();
    chk("t5_no_ovf", overflow, 0);
    chk("t5_valid", spk.spike_valid, 1);
    drain();
    set_cur(0, 0, 0, 0);
    pulse_tick();
    tick = 1'b1;
    clr_flags = 1'b1;
    step();
    tick = 1'b0;
    clr_flags = 1'b0;
    chk("t5_set_wins", tick_missed, 1);
    finish_scan();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t5_missed_clr", tick_missed, 0);

    // 6: reset in the middle of a scan
    do_reset();
    set_cur(100, 100, 100, 100);
    pulse_tick();
    step();
    chk("t6_mid_idx", cur_idx, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    step();
    rst_n = 1'b1;
    step();
    pulse_tick();
    chk("t6_fresh_idx", cur_idx, 0);
    chk("t6_fresh_busy", busy, 1);
    finish_scan();
    obs(0, 100, "t6_state0");
    obs(1, 100, "t6_state1");
    chk("t6_no_spike", spk.spike_valid, 0);

    chk("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
